tone_detector: RTL

- Receive side of the piano tone path: samples an external square-wave tone, measures its half-period in clk cycles and classifies it as one of 12 notes (C4..B4).
- Sits after a speaker/mic comparator or loopback pin; feeds the display/scoring logic.
- Note generators toggle every N+1 clocks; this block recovers N+1 and maps it to a note index.

---
 rtl/tone_detector.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - half-period meter and C4..B4 note classifier for a square-wave tone
// Optional glitch filter: define TONE_DET_GLITCH_FILTER_EN.
module tone_detector #(
  parameter int CNT_W    = 19,
  parameter int TOL      = 1024,
  parameter int CONFIRM  = 2,
  parameter int TIMEOUT  = 200000,
`ifdef TONE_DET_GLITCH_FILTER_EN
  parameter int MIN_HALF = 2000,
`endif
  // Divides the nominal table so a slower or scaled clock can reuse the classifier.
  parameter int NOM_DIV  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] half_period,
  output logic [3:0]       note_idx,
  output logic             note_valid,
  output logic             note_strobe
);

  localparam int MC_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [MC_W-1:0]  CONF_M1 = MC_W'(CONFIRM - 1);
  localparam logic [CNT_W-1:0] TOL_W   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TO_W    = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       NONE    = 4'd15;
`ifdef TONE_DET_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_HALF);
`endif

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_e;

  function automatic logic [CNT_W-1:0] nom(input logic [3:0] i);
    int v;
    case (i)
      4'd0:    v = 95556;
      4'd1:    v = 90194;
      4'd2:    v = 85131;
      4'd3:    v = 80353;
      4'd4:    v = 75843;
      4'd5:    v = 71586;
      4'd6:    v = 67569;
      4'd7:    v = 63776;
      4'd8:    v = 60197;
      4'd9:    v = 56818;
      4'd10:   v = 53630;
      4'd11:   v = 50620;
      default: v = 0;
    endcase
    return CNT_W'(v / NOM_DIV);
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [3:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic [3:0]       prev_q, prev_d;
  state_e           state_q, state_d;

  logic [CNT_W:0]   m_full;
  logic [CNT_W-1:0] m;
  logic             edge_raw, edge_use, timeout;
  logic [3:0]       cand;

  always_comb begin
    m_full   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    m        = m_full[CNT_W] ? {CNT_W{1'b1}} : m_full[CNT_W-1:0];
    edge_raw = s2_q ^ s3_q;
`ifdef TONE_DET_GLITCH_FILTER_EN
    edge_use = edge_raw && (m >= MIN_W);
`else
    edge_use = edge_raw;
`endif
    timeout  = (cnt_q == TO_W);
  end

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    logic [CNT_W-1:0] nv;
    logic [CNT_W-1:0] diff;
    cand = NONE;
    nv   = '0;
    diff = '0;
    for (int i = 11; i >= 0; i--) begin
      nv   = nom(4'(i));
      diff = (m >= nv) ? (m - nv) : (nv - m);
      if (diff <= TOL_W) cand = 4'(i);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (edge_use) cnt_d = '0;
    else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    match_d  = match_q;
    prev_d   = prev_q;
    if (edge_use) begin
      half_d = m;
      case (state_q)
        S_IDLE: begin
          state_d = S_MEASURE;
          match_d = '0;
          prev_d  = NONE;
        end
        S_MEASURE: begin
          if (cand != NONE && cand == prev_q) begin
            if (match_q >= CONF_M1) begin
              state_d  = S_LOCKED;
              match_d  = '0;
              strobe_d = !(valid_q && cand == idx_q);
              idx_d    = cand;
              valid_d  = 1'b1;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = MC_W'(cand != NONE);
            prev_d  = cand;
            if (cand == NONE) begin
              valid_d = 1'b0;
              idx_d   = NONE;
            end
          end
        end
        S_LOCKED: begin
          if (cand == NONE) begin
            state_d = S_MEASURE;
            valid_d = 1'b0;
            idx_d   = NONE;
            match_d = '0;
            prev_d  = NONE;
          end else if (cand != idx_q) begin
            // Old note stays displayed until the new one confirms.
            state_d = S_MEASURE;
            match_d = MC_W'(1);
            prev_d  = cand;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      idx_d   = NONE;
      match_d = '0;
      prev_d  = NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      half_q   <= '0;
      idx_q    <= NONE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      match_q  <= '0;
      prev_q   <= NONE;
      state_q  <= S_IDLE;
    end else begin
      s1_q     <= tone_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      match_q  <= match_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
    end
  end

  assign half_period = half_q;
  assign note_idx    = idx_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;

endmodule
